// File: rtl/page_stream_tx_pkg.sv
// ---------------------------------------------------------------------------
// page_stream_tx_pkg
// Shared definitions for the page stream transmitter: BFT packet field
// widths and bit offsets, the control port number on which freespace
// (credit return) packets arrive, credit limits and the transmit FSM states.
// ---------------------------------------------------------------------------
package page_stream_tx_pkg;

    // Field widths of the default BFT packet.
    localparam int PAYLOAD_W = 32;
    localparam int ADDR_W    = 7;
    localparam int PORT_W    = 4;
    localparam int LEAF_W    = 5;

    // Field offsets: [valid | leaf | port | addr | payload].
    localparam int ADDR_LSB  = PAYLOAD_W;
    localparam int PORT_LSB  = ADDR_LSB + ADDR_W;
    localparam int LEAF_LSB  = PORT_LSB + PORT_W;
    localparam int VALID_BIT = LEAF_LSB + LEAF_W;
    localparam int PACKET_W  = VALID_BIT + 1;

    // Port number reserved for control traffic (freespace updates).
    localparam int CTRL_PORT = 0;

    // Credit counter range: 0..CREDIT_MAX.
    localparam int CREDIT_W   = 8;
    localparam int CREDIT_MAX = 128;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } tx_state_e;

endpackage

// File: rtl/page_stream_tx_credit_counter.sv
// ---------------------------------------------------------------------------
// tx_credit_counter
// Tracks how many packets the downstream page may still accept. Reset loads
// CREDIT_MAX; each accepted word costs one credit; each freespace update adds
// UPDATE_SIZE, saturating at CREDIT_MAX. Both can happen in the same cycle.
//
// Ports
//   clk        clock
//   reset      synchronous active-high reset (credit := CREDIT_MAX)
//   dec        a word is accepted this cycle
//   inc        a freespace update arrives this cycle
//   zero       current credit is zero
//   next_zero  credit after this cycle's update will be zero
// ---------------------------------------------------------------------------
module tx_credit_counter
    import page_stream_tx_pkg::*;
#(
    parameter int CREDIT_BITS = CREDIT_W,
    parameter int MAX_CREDIT  = CREDIT_MAX,
    parameter int UPDATE_SIZE = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic dec,
    input  logic inc,
    output logic zero,
    output logic next_zero
);

    logic [CREDIT_BITS-1:0] credit;
    logic [CREDIT_BITS-1:0] credit_next;
    logic [CREDIT_BITS:0]   sum;   // one spare bit so credit + update cannot overflow

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here via the if/else covering all cases), so no latch is inferred.
    always_comb begin
        sum = {1'b0, credit}
            + (inc ? (CREDIT_BITS+1)'(UPDATE_SIZE) : '0)
            - (CREDIT_BITS+1)'(dec);
        if (sum > (CREDIT_BITS+1)'(MAX_CREDIT)) begin
            credit_next = CREDIT_BITS'(MAX_CREDIT);
        end else begin
            credit_next = sum[CREDIT_BITS-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit <= CREDIT_BITS'(MAX_CREDIT);
        end else begin
            credit <= credit_next;
        end
    end

    assign zero      = (credit == '0);
    assign next_zero = (credit_next == '0);

endmodule

// File: rtl/page_stream_tx.sv
// ---------------------------------------------------------------------------
// page_stream_tx
// Streams user payload words into a BFT network as addressed packets, one
// registered packet per accepted word. Flow control is credit based: the
// destination page starts with 128 free slots and returns credits in
// freespace packets sent to (SELF_LEAF, control port 0).
//
// Optional feature: define PAGE_STREAM_TX_STATS_EN to add the sent_count and
// stall_cycles statistics outputs.
//
// Ports
//   clk               clock
//   reset             synchronous active-high reset
//   din_user2tx       payload word
//   vld_user2tx       payload valid
//   ack_tx2user       payload accepted (combinational: RUN and credit != 0)
//   dest_leaf         destination leaf, captured with each accepted word
//   dest_port         destination port, captured with each accepted word
//   dout_leaf_tx2bft  packet to BFT, all zero when no packet is emitted
//   din_leaf_bft2tx   packet from BFT (only freespace updates are used)
//   sent_count        [stats] emitted packets, wraps at 2^32
//   stall_cycles      [stats] cycles spent in STALL, saturates
// ---------------------------------------------------------------------------
module page_stream_tx
    import page_stream_tx_pkg::*;
#(
    parameter int PACKET_BITS           = PACKET_W,
    parameter int PAYLOAD_BITS          = PAYLOAD_W,
    parameter int NUM_LEAF_BITS         = LEAF_W,
    parameter int NUM_PORT_BITS         = PORT_W,
    parameter int NUM_ADDR_BITS         = ADDR_W,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int SELF_LEAF             = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PAYLOAD_BITS-1:0]  din_user2tx,
    input  logic                     vld_user2tx,
    output logic                     ack_tx2user,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] dest_port,
    output logic [PACKET_BITS-1:0]   dout_leaf_tx2bft,
    input  logic [PACKET_BITS-1:0]   din_leaf_bft2tx
`ifdef PAGE_STREAM_TX_STATS_EN
    ,
    output logic [31:0]              sent_count,
    output logic [31:0]              stall_cycles
`endif
);

    // Offsets derived from the configured field widths.
    localparam int A_LSB = PAYLOAD_BITS;
    localparam int P_LSB = A_LSB + NUM_ADDR_BITS;
    localparam int L_LSB = P_LSB + NUM_PORT_BITS;
    localparam int V_BIT = L_LSB + NUM_LEAF_BITS;

    tx_state_e                state;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [PACKET_BITS-1:0]   dout_q;
    logic                     credit_zero;
    logic                     credit_next_zero;
    logic                     accept;
    logic                     freespace;

    assign ack_tx2user = (state == RUN) && !credit_zero;
    assign accept      = vld_user2tx && ack_tx2user;

    // A freespace update is a valid packet addressed to this leaf's control port.
    assign freespace = din_leaf_bft2tx[V_BIT]
        && (din_leaf_bft2tx[L_LSB +: NUM_LEAF_BITS] == NUM_LEAF_BITS'(SELF_LEAF))
        && (din_leaf_bft2tx[P_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(CTRL_PORT));

    // Address and payload bits of incoming packets carry no meaning here.
    logic unused_bft;
    assign unused_bft = ^din_leaf_bft2tx[P_LSB-1:0];

    tx_credit_counter #(
        .CREDIT_BITS (CREDIT_W),
        .MAX_CREDIT  (CREDIT_MAX),
        .UPDATE_SIZE (FREESPACE_UPDATE_SIZE)
    ) u_credit (
        .clk       (clk),
        .reset     (reset),
        .dec       (accept),
        .inc       (freespace),
        .zero      (credit_zero),
        .next_zero (credit_next_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= INIT;
            addr   <= '0;
            dout_q <= '0;
        end else begin
            unique case (state)
                INIT:    state <= RUN;
                RUN:     if (credit_next_zero)  state <= STALL;
                STALL:   if (!credit_next_zero) state <= RUN;
                default: state <= INIT;
            endcase

            // Destination is sampled together with the payload it belongs to.
            if (accept) begin
                dout_q <= {1'b1, dest_leaf, dest_port, addr, din_user2tx};
                addr   <= addr + 1'b1;
            end else begin
                dout_q <= '0;
            end
        end
    end

    assign dout_leaf_tx2bft = dout_q;

`ifdef PAGE_STREAM_TX_STATS_EN
    // sent_count steps on the same edge that loads the emitted packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            sent_count   <= '0;
            stall_cycles <= '0;
        end else begin
            if (accept) begin
                sent_count <= sent_count + 1'b1;
            end
            if ((state == STALL) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule
